// File: rtl/apb_mem_slave.sv
// APB completer fronting a small flop-array register memory, with fixed wait states.
// Optional error response for out-of-range/protocol-violating accesses: define APB_SLV_SLVERR_EN.
module apb_mem_slave #(
    parameter int ADDR_width  = 4,
    parameter int DATA_width  = 8,
    parameter int MEM_DEPTH   = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  P_clk,
    input  logic                  P_reset,
    input  logic                  P_sel,
    input  logic                  P_enable,
    input  logic                  P_write,
    input  logic [ADDR_width-1:0] P_addr,
    input  logic [DATA_width-1:0] P_wdata,
    output logic [DATA_width-1:0] P_rdata,
    output logic                  P_ready,
    output logic                  P_slverr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [ADDR_width-1:0] r_addr;
    logic [DATA_width-1:0] r_wdata;
    logic                  r_write;
    logic                  r_oor;
    logic                  r_perr;
    logic [DATA_width-1:0] r_rdata;
    logic                  r_ready;
    logic                  r_slverr;
    logic [DATA_width-1:0] r_mem [MEM_DEPTH];

    logic                  w_start;
    logic                  w_oor_live;
    logic                  w_perr_live;
    logic [DATA_width-1:0] w_rd_live;
    logic [DATA_width-1:0] w_rd_lat;
    logic                  w_commit;

    assign P_rdata  = r_rdata;
    assign P_ready  = r_ready;
    assign P_slverr = r_slverr;

    assign w_oor_live = ({1'b0, P_addr} >= (ADDR_width+1)'(MEM_DEPTH));

`ifdef APB_SLV_SLVERR_EN
    // A select with ENABLE already high is still served, but flagged and neutralised.
    assign w_start     = P_sel;
    assign w_perr_live = P_enable;
`else
    assign w_start     = P_sel & ~P_enable;
    assign w_perr_live = 1'b0;
`endif

    // Read muxes; an address with no populated word decodes to zero.
    always_comb begin
        w_rd_live = '0;
        w_rd_lat  = '0;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            if (P_addr == ADDR_width'(i)) w_rd_live = r_mem[i];
            if (r_addr == ADDR_width'(i)) w_rd_lat  = r_mem[i];
        end
    end

    assign w_commit = (r_state == S_ACK) & r_write & ~r_oor & ~r_perr;

    always_ff @(posedge P_clk or posedge P_reset) begin
        if (P_reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_write  <= 1'b0;
            r_oor    <= 1'b0;
            r_perr   <= 1'b0;
            r_rdata  <= '0;
            r_ready  <= 1'b0;
            r_slverr <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready  <= 1'b0;
                    r_slverr <= 1'b0;
                    if (w_start) begin
                        r_addr  <= P_addr;
                        r_write <= P_write;
                        r_wdata <= P_wdata;
                        r_oor   <= w_oor_live;
                        r_perr  <= w_perr_live;
                        r_cnt   <= 4'(WAIT_CYCLES);
                        if (WAIT_CYCLES == 0) begin
                            // No waits: the ACK cycle must already carry live-bus results.
                            r_state <= S_ACK;
                            r_ready <= 1'b1;
`ifdef APB_SLV_SLVERR_EN
                            r_slverr <= w_oor_live | w_perr_live;
`endif
                            if (!P_write || w_perr_live)
                                r_rdata <= (w_oor_live || w_perr_live) ? '0 : w_rd_live;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!P_sel) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == 4'd1) begin
                        r_state <= S_ACK;
                        r_ready <= 1'b1;
`ifdef APB_SLV_SLVERR_EN
                        r_slverr <= r_oor | r_perr;
`endif
                        if (!r_write || r_perr)
                            r_rdata <= (r_oor || r_perr) ? '0 : w_rd_lat;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    r_state  <= S_IDLE;
                    r_ready  <= 1'b0;
                    r_slverr <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_ready  <= 1'b0;
                    r_slverr <= 1'b0;
                end
            endcase
        end
    end

    // Writes land on the edge that closes ACK.
    always_ff @(posedge P_clk or posedge P_reset) begin
        if (P_reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
        end else if (w_commit) begin
            for (int i = 0; i < MEM_DEPTH; i++)
                if (r_addr == ADDR_width'(i)) r_mem[i] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: three instances with 0, 2 and 3 wait states.
module tb_apb_mem_slave;

    logic       clk;
    logic       sel, en, wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       rst0, rst2, rst3;
    logic [7:0] rd0, rd2, rd3;
    logic       rdy0, rdy2, rdy3;
    logic       se0, se2, se3;
    int         cur;
    logic [7:0] rdata;
    logic       rdy, slverr;

    int total = 0;
    int bad   = 0;

`ifdef APB_SLV_SLVERR_EN
    localparam logic EXP_SE = 1'b1;
`else
    localparam logic EXP_SE = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    apb_mem_slave #(.WAIT_CYCLES(0)) u_w0 (
        .P_clk(clk), .P_reset(rst0), .P_sel(sel && cur == 0), .P_enable(en),
        .P_write(wr), .P_addr(addr), .P_wdata(wdata),
        .P_rdata(rd0), .P_ready(rdy0), .P_slverr(se0));

    apb_mem_slave #(.WAIT_CYCLES(2)) u_w2 (
        .P_clk(clk), .P_reset(rst2), .P_sel(sel && cur == 2), .P_enable(en),
        .P_write(wr), .P_addr(addr), .P_wdata(wdata),
        .P_rdata(rd2), .P_ready(rdy2), .P_slverr(se2));

    apb_mem_slave #(.WAIT_CYCLES(3)) u_w3 (
        .P_clk(clk), .P_reset(rst3), .P_sel(sel && cur == 3), .P_enable(en),
        .P_write(wr), .P_addr(addr), .P_wdata(wdata),
        .P_rdata(rd3), .P_ready(rdy3), .P_slverr(se3));

    always_comb begin
        rdata = rd0; rdy = rdy0; slverr = se0;
        case (cur)
            2: begin rdata = rd2; rdy = rdy2; slverr = se2; end
            3: begin rdata = rd3; rdy = rdy3; slverr = se3; end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; returns just after the negedge following ACK.
    task automatic xfer(input logic w, input logic [3:0] a, input logic [7:0] d,
                        output logic [7:0] r, output int waits, output logic e);
        sel = 1'b1; en = 1'b0; wr = w; addr = a; wdata = d;
        waits = 0;
        @(negedge clk);
        en = 1'b1;
        while (!rdy && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        r = rdata;
        e = slverr;
        @(negedge clk);
        sel = 1'b0; en = 1'b0;
        chk("rdy_one_cycle", rdy, 0);
        chk("se_after_ack", slverr, 0);
    endtask

    logic [7:0] r;
    int         w;
    logic       e;
    int         nrdy;

    initial begin
        cur = 0; sel = 0; en = 0; wr = 0; addr = 0; wdata = 0;
        rst0 = 0; rst2 = 0; rst3 = 0;
        #2 rst0 = 1; rst2 = 1; rst3 = 1;
        #1;
        chk("rst_rdy",  {rdy0, rdy2, rdy3}, 0);
        chk("rst_se",   {se0, se2, se3}, 0);
        chk("rst_rdata", {rd0, rd2, rd3}, 0);
        @(negedge clk);
        rst0 = 0; rst2 = 0; rst3 = 0;
        @(negedge clk);

        // zero-wait write then read
        cur = 0;
        xfer(1, 4'd5, 8'h3C, r, w, e);
        chk("w0_wr_waits", w, 0);
        chk("w0_wr_se", e, 0);
        chk("w0_wr_rdata_kept", r, 0);
        xfer(0, 4'd5, 8'h00, r, w, e);
        chk("w0_rd_waits", w, 0);
        chk("w0_rd_data", r, 8'h3C);
        chk("w0_rd_se", e, 0);

        // out of range
        xfer(1, 4'd14, 8'hFF, r, w, e);
        chk("oor_wr_se", e, EXP_SE);
        xfer(0, 4'd14, 8'h00, r, w, e);
        chk("oor_rd_data", r, 0);
        chk("oor_rd_se", e, EXP_SE);

        // back-to-back fill then readback
        for (int i = 0; i < 12; i++) begin
            xfer(1, 4'(i), 8'hA0 + 8'(i), r, w, e);
            chk("b2b_wr_waits", w, 0);
        end
        for (int i = 0; i < 12; i++) begin
            xfer(0, 4'(i), 8'h00, r, w, e);
            chk("b2b_rd_data", r, 8'hA0 + 8'(i));
            chk("b2b_rd_waits", w, 0);
        end

        // two wait states
        cur = 2;
        xfer(1, 4'd0, 8'h81, r, w, e);
        chk("w2_wr_waits", w, 2);
        xfer(0, 4'd0, 8'h00, r, w, e);
        chk("w2_rd_waits", w, 2);
        chk("w2_rd_data", r, 8'h81);

        // abort during WAIT
        cur = 3;
        xfer(1, 4'd1, 8'h11, r, w, e);
        chk("w3_wr_waits", w, 3);
        sel = 1; en = 0; wr = 1; addr = 4'd1; wdata = 8'h77;
        @(negedge clk);
        en = 1;
        chk("abort_t1_rdy", rdy, 0);
        @(negedge clk);
        sel = 0; en = 0;
        nrdy = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rdy) nrdy++;
        end
        chk("abort_no_ready", nrdy, 0);
        xfer(0, 4'd1, 8'h00, r, w, e);
        chk("abort_rd_data", r, 8'h11);
        chk("abort_rd_waits", w, 3);

        // reset during second wait cycle
        xfer(1, 4'd3, 8'h5A, r, w, e);
        xfer(0, 4'd3, 8'h00, r, w, e);
        chk("pre_rst_rd", r, 8'h5A);
        sel = 1; en = 0; wr = 1; addr = 4'd2; wdata = 8'hA5;
        @(negedge clk);
        en = 1;
        @(negedge clk);
        rst3 = 1;
        #1;
        chk("midrst_rdy", rdy3, 0);
        chk("midrst_rdata", rd3, 0);
        chk("midrst_se", se3, 0);
        sel = 0; en = 0;
        @(negedge clk);
        rst3 = 0;
        @(negedge clk);
        xfer(0, 4'd2, 8'h00, r, w, e);
        chk("midrst_rd2", r, 0);
        chk("midrst_rd2_waits", w, 3);
        xfer(0, 4'd3, 8'h00, r, w, e);
        chk("midrst_rd3_cleared", r, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
